fft_stage_sched: RTL and testbench

Sequencer for the in-place radix-2 DIT FFT (8192 points, 13 stages). On each `start` it walks every stage and every butterfly, emitting per butterfly the two data-BRAM addresses and the twiddle-factor BRAM address plus read enable. It sits between the top-level control and the data BRAM / twiddle provider / butterfly pipeline, with a valid/ready handshake toward the butterfly.

---
 rtl/fft_pkg.sv | 24 ++
 rtl/fft_stage_sched_if.sv | 35 +++
 rtl/fft_bf_addr_gen.sv | 38 +++
 rtl/fft_stage_sched.sv | 164 ++++++++++++++++
 tb/tb_fft_stage_sched.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/fft_pkg.sv
// fft_pkg: shared constants, stage type and sequencer state encoding for the FFT scheduler.
// Rev 1.0
`default_nettype none

package fft_pkg;

   localparam int c_BRAM_ADDR_LEN = 13;
   localparam int c_N             = 1 << c_BRAM_ADDR_LEN;
   localparam int c_STAGE_NUM     = 13;
   localparam int c_TF_ADDR_LEN   = 12;
   localparam int c_PIPE_DEPTH    = 8;

   typedef logic [3:0] stage_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      FIN   = 2'd3
   } state_t;

endpackage

`default_nettype wire

// File: rtl/fft_stage_sched_if.sv
// fft_stage_sched_if: control and butterfly-handshake bundle between the scheduler and its clients.
// Rev 1.0
`default_nettype none

interface fft_stage_sched_if #(
   parameter int BRAM_ADDR_LEN = 13,
   parameter int TF_ADDR_LEN   = 12
);
   import fft_pkg::*;

   logic                     start;
   logic                     bf_ready;
   logic                     bf_valid;
   logic [BRAM_ADDR_LEN-1:0] addr_a;
   logic [BRAM_ADDR_LEN-1:0] addr_b;
   logic [TF_ADDR_LEN-1:0]   tf_addr;
   logic                     tf_en;
   stage_t                   stage;
   logic                     last_bf;
   logic                     busy;
   logic                     done;

   modport master (
      input  start, bf_ready,
      output bf_valid, addr_a, addr_b, tf_addr, tf_en, stage, last_bf, busy, done
   );

   modport slave (
      output start, bf_ready,
      input  bf_valid, addr_a, addr_b, tf_addr, tf_en, stage, last_bf, busy, done
   );

endinterface

`default_nettype wire

// File: rtl/fft_bf_addr_gen.sv
// fft_bf_addr_gen: combinational (stage, butterfly) -> leg addresses, twiddle index, last flag.
// Rev 1.0
`default_nettype none

module fft_bf_addr_gen
   import fft_pkg::*;
#(
   parameter int BRAM_ADDR_LEN = 13,
   parameter int STAGE_NUM     = 13,
   parameter int TF_ADDR_LEN   = 12
) (
   input  wire stage_t                   i_s,
   input  wire [BRAM_ADDR_LEN-2:0]       i_k,
   output logic [BRAM_ADDR_LEN-1:0]      o_addr_a,
   output logic [BRAM_ADDR_LEN-1:0]      o_addr_b,
   output logic [TF_ADDR_LEN-1:0]        o_tf_addr,
   output logic                          o_last_bf
);

   logic [BRAM_ADDR_LEN-1:0] w_k_ext;
   logic [BRAM_ADDR_LEN-1:0] w_span;
   logic [BRAM_ADDR_LEN-1:0] w_j;
   stage_t                   w_tf_sh;

   assign w_k_ext = {1'b0, i_k};
   assign w_span  = BRAM_ADDR_LEN'(1) << i_s;
   assign w_j     = w_k_ext & (w_span - BRAM_ADDR_LEN'(1));
   assign w_tf_sh = stage_t'(STAGE_NUM - 1) - i_s;

   // Group index k>>s is spread over blocks of 2^(s+1); j selects the position inside the block.
   assign o_addr_a  = ((w_k_ext >> i_s) << stage_t'(i_s + 4'd1)) | w_j;
   assign o_addr_b  = o_addr_a + w_span;
   assign o_tf_addr = TF_ADDR_LEN'(w_j << w_tf_sh);
   assign o_last_bf = &i_k;

endmodule

`default_nettype wire

// File: rtl/fft_stage_sched.sv
// fft_stage_sched: radix-2 DIT stage/butterfly sequencer with valid/ready handshake.
// Define FFT_SCHED_DRAIN_EN to insert a PIPE_DEPTH-cycle drain gap between stages.  Rev 1.0
`default_nettype none

module fft_stage_sched
   import fft_pkg::*;
#(
   parameter int BRAM_ADDR_LEN = $clog2(c_N),
   parameter int STAGE_NUM     = c_STAGE_NUM,
   parameter int TF_ADDR_LEN   = c_TF_ADDR_LEN,
   parameter int PIPE_DEPTH    = c_PIPE_DEPTH
) (
   input  wire                 clk,
   input  wire                 rst_n,
   fft_stage_sched_if.master   bus
);

   localparam int             c_KW     = BRAM_ADDR_LEN - 1;
   localparam logic [c_KW-1:0] c_K_LAST = '1;
   localparam stage_t         c_S_LAST = stage_t'(STAGE_NUM - 1);

   if ((STAGE_NUM != BRAM_ADDR_LEN) || (TF_ADDR_LEN != BRAM_ADDR_LEN - 1) || (PIPE_DEPTH < 1)) begin : g_cfg_err
      $error("fft_stage_sched: inconsistent parameter set");
   end

   state_t                   r_state, w_state_nxt;
   stage_t                   r_s, w_s_nxt;
   logic [c_KW-1:0]          r_k, w_k_nxt;
   logic                     r_valid, w_valid_nxt;
   logic                     r_busy, w_busy_nxt;
   logic                     r_done, w_done_nxt;
   logic                     w_acc;
   logic [BRAM_ADDR_LEN-1:0] r_addr_a, r_addr_b, w_addr_a, w_addr_b;
   logic [TF_ADDR_LEN-1:0]   r_tf_addr, w_tf_addr;
   logic                     r_last_bf, w_last_bf;

`ifdef FFT_SCHED_DRAIN_EN
   localparam int             c_CW       = $clog2(PIPE_DEPTH + 1);
   localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(PIPE_DEPTH - 1);
   logic [c_CW-1:0]          r_cnt, w_cnt_nxt;
`endif

   assign w_acc = r_valid & bus.bf_ready;

   always_comb begin
      w_state_nxt = r_state;
      w_s_nxt     = r_s;
      w_k_nxt     = r_k;
      w_valid_nxt = 1'b0;
      w_busy_nxt  = r_busy;
      w_done_nxt  = 1'b0;
`ifdef FFT_SCHED_DRAIN_EN
      w_cnt_nxt   = r_cnt;
`endif
      case (r_state)
         IDLE: begin
            if (bus.start) begin
               w_state_nxt = RUN;
               w_s_nxt     = '0;
               w_k_nxt     = '0;
               w_valid_nxt = 1'b1;
               w_busy_nxt  = 1'b1;
            end
         end
         RUN: begin
            w_valid_nxt = 1'b1;
            if (w_acc) begin
               if (r_k == c_K_LAST) begin
                  w_k_nxt = '0;
                  if (r_s == c_S_LAST) begin
                     w_state_nxt = FIN;
                     w_s_nxt     = '0;
                     w_valid_nxt = 1'b0;
                     w_busy_nxt  = 1'b0;
                     w_done_nxt  = 1'b1;
                  end else begin
`ifdef FFT_SCHED_DRAIN_EN
                     w_state_nxt = DRAIN;
                     w_cnt_nxt   = '0;
                     w_valid_nxt = 1'b0;
`else
                     w_s_nxt     = stage_t'(r_s + 4'd1);
`endif
                  end
               end else begin
                  w_k_nxt = r_k + 1'b1;
               end
            end
         end
`ifdef FFT_SCHED_DRAIN_EN
         DRAIN: begin
            if (r_cnt == c_CNT_LAST) begin
               w_state_nxt = RUN;
               w_s_nxt     = stage_t'(r_s + 4'd1);
               w_valid_nxt = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
`endif
         FIN:     w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Addresses are computed from the next counters so they appear registered alongside bf_valid.
   fft_bf_addr_gen #(
      .BRAM_ADDR_LEN (BRAM_ADDR_LEN),
      .STAGE_NUM     (STAGE_NUM),
      .TF_ADDR_LEN   (TF_ADDR_LEN)
   ) u_addr_gen (
      .i_s       (w_s_nxt),
      .i_k       (w_k_nxt),
      .o_addr_a  (w_addr_a),
      .o_addr_b  (w_addr_b),
      .o_tf_addr (w_tf_addr),
      .o_last_bf (w_last_bf)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_s       <= '0;
         r_k       <= '0;
         r_valid   <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_addr_a  <= '0;
         r_addr_b  <= '0;
         r_tf_addr <= '0;
         r_last_bf <= 1'b0;
`ifdef FFT_SCHED_DRAIN_EN
         r_cnt     <= '0;
`endif
      end else begin
         r_state   <= w_state_nxt;
         r_s       <= w_s_nxt;
         r_k       <= w_k_nxt;
         r_valid   <= w_valid_nxt;
         r_busy    <= w_busy_nxt;
         r_done    <= w_done_nxt;
         r_addr_a  <= w_valid_nxt ? w_addr_a  : '0;
         r_addr_b  <= w_valid_nxt ? w_addr_b  : '0;
         r_tf_addr <= w_valid_nxt ? w_tf_addr : '0;
         r_last_bf <= w_valid_nxt & w_last_bf;
`ifdef FFT_SCHED_DRAIN_EN
         r_cnt     <= w_cnt_nxt;
`endif
      end
   end

   assign bus.bf_valid = r_valid;
   assign bus.addr_a   = r_addr_a;
   assign bus.addr_b   = r_addr_b;
   assign bus.tf_addr  = r_tf_addr;
   assign bus.tf_en    = r_valid & bus.bf_ready;
   assign bus.stage    = r_s;
   assign bus.last_bf  = r_last_bf;
   assign bus.busy     = r_busy;
   assign bus.done     = r_done;

endmodule

`default_nettype wire

// File: tb/tb_fft_stage_sched.sv
// tb_fft_stage_sched: directed sequence with randomized bf_ready, checked against an arithmetic reference model.
// Rev 1.0
`default_nettype none

module tb_fft_stage_sched;

   localparam int PD = 8;
`ifdef FFT_SCHED_DRAIN_EN
   localparam int GAP = PD;
`else
   localparam int GAP = 0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fft_stage_sched_if #(.BRAM_ADDR_LEN(13), .TF_ADDR_LEN(12)) bus ();

   fft_stage_sched #(
      .BRAM_ADDR_LEN (13),
      .STAGE_NUM     (13),
      .TF_ADDR_LEN   (12),
      .PIPE_DEPTH    (PD)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_chk  = 0;
   int n_pass = 0;
   int n_fail = 0;

   // Reference model state: next expected butterfly and remaining gap cycles.
   bit running   = 1'b0;
   bit exp_done  = 1'b0;
   bit fin       = 1'b0;
   int es        = 0;
   int ek        = 0;
   int gap_left  = 0;
   int cyc       = 0;
   int start_cyc = 0;

   function automatic int ref_a(input int s, input int k);
      int j;
      j = k % (1 << s);
      return (k / (1 << s)) * (1 << (s + 1)) + j;
   endfunction

   function automatic int ref_tf(input int s, input int k);
      int j;
      j = k % (1 << s);
      return (j * (1 << (12 - s))) % 4096;
   endfunction

   task automatic finish_run();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d (stage %0d k %0d)", tag, obs, exp, es, ek);
      end
      if (n_fail >= 25) finish_run();
   endtask

   task automatic step(input bit drv_start, input int ready_pct, input bit strict_lat);
      bit exp_v;
      bit rdy;
      @(negedge clk);
      cyc++;
      exp_v = running && (gap_left == 0);
      chk("bf_valid", bus.bf_valid, exp_v);
      chk("busy", bus.busy, running);
      chk("done", bus.done, exp_done);
      if (exp_done) begin
         fin = 1'b1;
         if (strict_lat) chk("latency", cyc - start_cyc + 1, 2 + 13 * 4096 + 12 * GAP);
      end
      if (exp_v) begin
         chk("stage", bus.stage, es);
         chk("addr_a", bus.addr_a, ref_a(es, ek));
         chk("addr_b", bus.addr_b, ref_a(es, ek) + (1 << es));
         chk("tf_addr", bus.tf_addr, ref_tf(es, ek));
         chk("last_bf", bus.last_bf, ek == 4095);
         if (es == 0 && ek < 3) begin
            chk("s0_addr_a", bus.addr_a, 2 * ek);
            chk("s0_addr_b", bus.addr_b, 2 * ek + 1);
            chk("s0_tf", bus.tf_addr, 0);
         end
         if (es == 12 && ek == 5) begin
            chk("s12k5_a", bus.addr_a, 5);
            chk("s12k5_b", bus.addr_b, 4101);
            chk("s12k5_tf", bus.tf_addr, 5);
         end
         if (es == 3 && ek == 9) begin
            chk("s3k9_a", bus.addr_a, 17);
            chk("s3k9_b", bus.addr_b, 25);
            chk("s3k9_tf", bus.tf_addr, 512);
         end
      end
      rdy = ($urandom_range(99) < ready_pct);
      bus.bf_ready = rdy;
      bus.start    = drv_start;
      #1;
      chk("tf_en", bus.tf_en, exp_v && rdy);
      exp_done = 1'b0;
      if (exp_v && rdy) begin
         if (ek == 4095) begin
            ek = 0;
            if (es == 12) begin
               running  = 1'b0;
               exp_done = 1'b1;
            end else begin
               es++;
               gap_left = GAP;
            end
         end else begin
            ek++;
         end
      end else if (running && gap_left > 0) begin
         gap_left--;
      end else if (!running && drv_start) begin
         running   = 1'b1;
         es        = 0;
         ek        = 0;
         gap_left  = 0;
         start_cyc = cyc;
      end
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_valid"}, bus.bf_valid, 0);
      chk({tag, "_busy"}, bus.busy, 0);
      chk({tag, "_done"}, bus.done, 0);
      chk({tag, "_addr_a"}, bus.addr_a, 0);
      chk({tag, "_addr_b"}, bus.addr_b, 0);
      chk({tag, "_tf_addr"}, bus.tf_addr, 0);
      chk({tag, "_tf_en"}, bus.tf_en, 0);
      chk({tag, "_stage"}, bus.stage, 0);
      chk({tag, "_last_bf"}, bus.last_bf, 0);
   endtask

   initial begin
      bus.start    = 1'b0;
      bus.bf_ready = 1'b0;
      rst_n        = 1'b0;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst_n = 1'b1;

      // Full transform, no stalls, with a spurious start mid-run.
      repeat (2) step(1'b0, 100, 1'b0);
      step(1'b1, 100, 1'b0);
      fin = 1'b0;
      for (int i = 0; i < 60000 && !fin; i++) step(i == 1000, 100, 1'b1);
      chk("full_run_done_seen", fin, 1);
      repeat (3) step(1'b0, 100, 1'b0);

      // Random stalls, then abort by reset in stage 5.
      step(1'b1, 80, 1'b0);
      for (int i = 0; i < 40000 && !(running && es == 5 && ek == 100); i++) step(1'b0, 80, 1'b0);
      chk("reached_stage5", es, 5);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_all_zero("abort");
      running  = 1'b0;
      exp_done = 1'b0;
      gap_left = 0;
      repeat (3) step(1'b0, 50, 1'b0);
      rst_n = 1'b1;
      repeat (5) step(1'b0, 50, 1'b0);

      // Fresh start after the abort begins again at stage 0.
      step(1'b1, 100, 1'b0);
      repeat (8) step(1'b0, 100, 1'b0);
      chk("restart_stage", es, 0);
      chk("restart_k", ek, 8);

      finish_run();
   end

endmodule

`default_nettype wire
